// File: rtl/vec_wmul_seq.sv
// Sequential widening multiply: even- or odd-indexed elements of A and B become
// double-width products, MPC of them per clock, behind valid/ready handshakes.
module vec_wmul_seq #(
  parameter int DW  = 128,
  parameter int MPC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:DW-1] reg_A,
  input  logic [0:DW-1] reg_B,
  input  logic [0:1]    ctrl_ww,
  input  logic          op_odd,
  input  logic          op_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:DW-1] result,
  output logic          busy
);

  localparam int NP8  = DW / 16;
  localparam int NP16 = DW / 32;
  localparam int NP32 = DW / 64;
  localparam int IW   = $clog2(NP8 + MPC) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [0:DW-1] res_r;
  logic [0:DW-1] res_nxt;
  logic [0:DW-1] a_r;
  logic [0:DW-1] b_r;
  logic [1:0]    ww_r;
  logic          odd_r;
  logic          sgn_r;
  int            np;
  logic          last;

  // A one-bit extension is enough: the sign bit (or zero) widens each operand,
  // and the low 2E bits of the signed product are the exact result.
  function automatic logic [15:0] wmul8(input logic [7:0] a, input logic [7:0] b,
                                        input logic sgn);
    logic signed [8:0]  ea;
    logic signed [8:0]  eb;
    logic signed [17:0] p;
    ea = {sgn & a[7], a};
    eb = {sgn & b[7], b};
    p  = ea * eb;
    return p[15:0];
  endfunction

  function automatic logic [31:0] wmul16(input logic [15:0] a, input logic [15:0] b,
                                         input logic sgn);
    logic signed [16:0] ea;
    logic signed [16:0] eb;
    logic signed [33:0] p;
    ea = {sgn & a[15], a};
    eb = {sgn & b[15], b};
    p  = ea * eb;
    return p[31:0];
  endfunction

  function automatic logic [63:0] wmul32(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [32:0] ea;
    logic signed [32:0] eb;
    logic signed [65:0] p;
    ea = {sgn & a[31], a};
    eb = {sgn & b[31], b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  // The unsupported w64 code is sequenced like w32 but never writes a product.
  always_comb begin
    case (ww_r)
      2'b00:   np = NP8;
      2'b01:   np = NP16;
      default: np = NP32;
    endcase
    last = (int'(idx) + MPC) >= np;
  end

  always_comb begin
    res_nxt = res_r;
    for (int m = 0; m < MPC; m++) begin
      int p;
      int sel;
      p   = int'(idx) + m;
      sel = 2 * p + (odd_r ? 1 : 0);
      case (ww_r)
        2'b00: if (p < NP8)
          res_nxt[16*p +: 16] = wmul8(a_r[8*sel +: 8], b_r[8*sel +: 8], sgn_r);
        2'b01: if (p < NP16)
          res_nxt[32*p +: 32] = wmul16(a_r[16*sel +: 16], b_r[16*sel +: 16], sgn_r);
        2'b10: if (p < NP32)
          res_nxt[64*p +: 64] = wmul32(a_r[32*sel +: 32], b_r[32*sel +: 32], sgn_r);
        default: ;
      endcase
    end
  end

  // ---- operand capture (accept edge only) ----
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      a_r   <= reg_A;
      b_r   <= reg_B;
      ww_r  <= ctrl_ww;
      odd_r <= op_odd;
      sgn_r <= op_signed;
    end
  end

  // ---- control and result register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      res_r <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          state <= S_MUL;
          idx   <= '0;
          res_r <= '0;
        end
        S_MUL: begin
          res_r <= res_nxt;
          idx   <= idx + IW'(MPC);
          if (last) state <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_MUL) || (state == S_DONE);
  assign result    = res_r;

endmodule

// File: tb/tb_vec_wmul_seq.sv
// Bench for vec_wmul_seq: an MPC=1 and an MPC=4 instance driven in lockstep,
// checked against spec vectors and a numeric reference model.
module tb_vec_wmul_seq;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [0:127] reg_A;
  logic [0:127] reg_B;
  logic [0:1]   ctrl_ww;
  logic         op_odd;
  logic         op_signed;

  logic         in_ready1, out_valid1, busy1;
  logic [0:127] result1;
  logic         in_ready4, out_valid4, busy4;
  logic [0:127] result4;

  int checks;
  int failures;

  vec_wmul_seq #(.DW(128), .MPC(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .reg_A(reg_A), .reg_B(reg_B), .ctrl_ww(ctrl_ww), .op_odd(op_odd),
    .op_signed(op_signed), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .busy(busy1)
  );

  vec_wmul_seq #(.DW(128), .MPC(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .reg_A(reg_A), .reg_B(reg_B), .ctrl_ww(ctrl_ww), .op_odd(op_odd),
    .op_signed(op_signed), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Elements are numbered from the most significant end of the hex value.
  function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b,
                                           input logic [1:0] ww, input logic odd,
                                           input logic sgn);
    logic [127:0] r;
    logic [127:0] emask;
    logic [63:0]  pmask;
    logic [63:0]  prod;
    longint       ea;
    longint       eb;
    int           e;
    int           np;
    int           j;
    r = '0;
    if (ww == 2'b11) return r;
    e     = 8 << ww;
    np    = 128 / (2 * e);
    emask = (128'd1 << e) - 128'd1;
    pmask = (64'd1 << (2 * e)) - 64'd1;
    for (int i = 0; i < np; i++) begin
      j  = 2 * i + (odd ? 1 : 0);
      ea = longint'((a >> (128 - e * (j + 1))) & emask);
      eb = longint'((b >> (128 - e * (j + 1))) & emask);
      if (sgn && ea[e-1]) ea = ea - (longint'(1) << e);
      if (sgn && eb[e-1]) eb = eb - (longint'(1) << e);
      prod = 64'(ea * eb) & pmask;
      r = r | (128'(prod) << (128 - 2 * e * (i + 1)));
    end
    return r;
  endfunction

  task automatic do_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                       input logic [1:0] ww, input logic odd, input logic sgn,
                       input logic [127:0] exp, input int hold);
    int np;
    int lat1;
    int lat4;
    int j;
    np = (ww == 2'b00) ? 8 : (ww == 2'b01) ? 4 : 2;
    @(negedge clk);
    chk({tag, ".in_ready"}, {in_ready1, in_ready4}, 128'd3);
    reg_A = a; reg_B = b; ctrl_ww = ww; op_odd = odd; op_signed = sgn;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    reg_A     = {$urandom, $urandom, $urandom, $urandom};
    reg_B     = {$urandom, $urandom, $urandom, $urandom};
    ctrl_ww   = 2'($urandom);
    op_odd    = 1'($urandom);
    op_signed = 1'($urandom);
    lat1 = 0; lat4 = 0; j = 0;
    while ((lat1 == 0 || lat4 == 0) && j < 40) begin
      @(posedge clk); #1;
      j++;
      if (lat1 == 0 && out_valid1) lat1 = j;
      if (lat4 == 0 && out_valid4) lat4 = j;
    end
    chk({tag, ".lat1"}, 128'(lat1), 128'(np));
    chk({tag, ".lat4"}, 128'((np + 3) / 4), 128'(lat4) == 128'(lat4) ? 128'((np + 3) / 4) : 128'd0);
    chk({tag, ".lat4v"}, 128'(lat4), 128'((np + 3) / 4));
    chk({tag, ".res1"}, result1, exp);
    chk({tag, ".res4"}, result4, exp);
    chk({tag, ".busy"}, {busy1, busy4}, 128'd3);
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid;
      reg_A    = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk({tag, ".hold_res1"}, result1, exp);
      chk({tag, ".hold_res4"}, result4, exp);
      chk({tag, ".hold_rdy"}, {in_ready1, in_ready4}, 128'd0);
      chk({tag, ".hold_ov"}, {out_valid1, out_valid4}, 128'd3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".post_rdy"}, {in_ready1, in_ready4}, 128'd3);
    chk({tag, ".post_ov"}, {out_valid1, out_valid4}, 128'd0);
  endtask

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    logic [1:0]   ww;
    logic         odd;
    logic         sgn;
    checks = 0; failures = 0;
    clk = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    reg_A = '0; reg_B = '0; ctrl_ww = 2'b00; op_odd = 1'b0; op_signed = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", {in_ready1, in_ready4}, 128'd3);
    chk("rst.out_valid", {out_valid1, out_valid4}, 128'd0);
    chk("rst.busy", {busy1, busy4}, 128'd0);
    chk("rst.res1", result1, 128'd0);
    chk("rst.res4", result4, 128'd0);
    @(negedge clk) reset = 1'b0;

    do_op("w8_even_u", 128'h0402030405060708f00a0b0cff0eff00,
          128'h03010202030303031004f505ff09fe10, 2'b00, 1'b0, 1'b0,
          128'h000c0006000f00150f000a87fe01fd02, 0);
    do_op("w16_odd_u", 128'h0001000200000008000f10bff103ffff,
          128'h0002000400060008000c001000120014, 2'b01, 1'b1, 1'b0,
          128'h000000080000004000010bf00013ffec, 0);
    do_op("w16_odd_s", 128'h1111000211118000111120541111fff9,
          128'hffff0004ffff7fffffff0000fffffffd, 2'b01, 1'b1, 1'b1,
          128'h00000008c00080000000000000000015, 5);
    do_op("w32_even_s", 128'hffffffff000000000000000200000000,
          128'h00000005000000008000000000000000, 2'b10, 1'b0, 1'b1,
          128'hfffffffffffffffbffffffff00000000, 0);
    do_op("w32_even_u", 128'hffffffff000000000000000200000000,
          128'h00000005000000008000000000000000, 2'b10, 1'b0, 1'b0,
          128'h00000004fffffffb0000000100000000, 0);
    do_op("w64_zero", 128'h123456789abcdef0fedcba9876543210,
          128'h0f0f0f0f0f0f0f0ff0f0f0f0f0f0f0f0, 2'b11, 1'b0, 1'b1,
          128'h0, 1);

    // Abort an MPC=1 w8 operation after its third product.
    @(negedge clk);
    reg_A = 128'h0402030405060708f00a0b0cff0eff00;
    reg_B = 128'h03010202030303031004f505ff09fe10;
    ctrl_ww = 2'b00; op_odd = 1'b0; op_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid.partial", result1, 128'h000c0006000f00000000000000000000);
    reset = 1'b1;
    #1;
    chk("mid.res1", result1, 128'd0);
    chk("mid.res4", result4, 128'd0);
    chk("mid.out_valid", {out_valid1, out_valid4}, 128'd0);
    chk("mid.in_ready", {in_ready1, in_ready4}, 128'd3);
    chk("mid.busy", {busy1, busy4}, 128'd0);
    @(negedge clk) reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid.no_ov", {out_valid1, out_valid4}, 128'd0);
    end
    do_op("after_rst", 128'h0402030405060708f00a0b0cff0eff00,
          128'h03010202030303031004f505ff09fe10, 2'b00, 1'b0, 1'b0,
          128'h000c0006000f00150f000a87fe01fd02, 0);

    for (int n = 0; n < 24; n++) begin
      a   = {$urandom, $urandom, $urandom, $urandom};
      b   = {$urandom, $urandom, $urandom, $urandom};
      ww  = 2'($urandom);
      odd = 1'($urandom);
      sgn = 1'($urandom);
      do_op($sformatf("rand%0d", n), a, b, ww, odd, sgn, ref_mul(a, b, ww, odd, sgn),
            $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
